reaction_game_ctrl: RTL and testbench

- Multi-round reaction-time game controller; the next generation of the single-round game state machine.
- Owns its own random-delay generator (LFSR) and millisecond reaction timer.
- Runs ROUNDS rounds, scores early/late attempts with a penalty, and reports per-round time, best hit and average.
- Sits between the debounced button pulses / 1 ms tick generator and the display/LED drivers.

---
 rtl/reaction_game_pkg.sv | 25 ++
 rtl/reaction_game_ctrl_lfsr16.sv | 25 ++
 rtl/reaction_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_reaction_game_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_game_pkg.sv
// Shared types and constants for the multi-round reaction-time game:
// the state encoding, the LFSR feedback mask and the penalty-time helper.
package reaction_game_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_GO    = 3'd2,
      S_HIT   = 3'd3,
      S_LATE  = 3'd4,
      S_EARLY = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   // Feedback mask for taps 16,14,13,11 (bit n-1 holds tap n).
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Time recorded for EARLY/LATE rounds, clamped to what a TIME_W value can hold.
   function automatic int penalty_ms(input int timeout_ms, input int time_w);
      int max_v;
      max_v = (1 << time_w) - 1;
      return (timeout_ms > max_v) ? max_v : timeout_ms;
   endfunction

endpackage

// File: rtl/reaction_game_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR that shifts left every cycle; the source of the
// random pre-GO delay.
module lfsr16
   import reaction_game_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
)(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   logic [15:0] r_q;
   logic        w_fb;

   assign w_fb = ^(r_q & LFSR_TAPS);

   always_ff @(posedge clk) begin
      if (rst) r_q <= SEED;
      else     r_q <= {r_q[14:0], w_fb};
   end

   assign q = r_q;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Multi-round reaction game controller: random wait, ms reaction timer,
// per-round scoring with penalties, best hit and average over the game.
module reaction_game_ctrl
   import reaction_game_pkg::*;
#(
   parameter int          ROUNDS        = 4,
   parameter int          TIME_W        = 10,
   parameter int          TIMEOUT_MS    = 1000,
   parameter int          MIN_DELAY_MS  = 1000,
   parameter int          RAND_RANGE_MS = 2048,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ms_tick,
   input  logic                     btn_start,
   input  logic                     btn_stop,
   input  logic                     btn_clear,
   output logic [2:0]               state_out,
   output logic                     led_go,
   output logic [TIME_W-1:0]        react_ms,
   output logic                     result_valid,
   output logic [$clog2(ROUNDS):0]  round_idx,
   output logic [TIME_W-1:0]        best_ms,
   output logic [TIME_W-1:0]        avg_ms,
   output logic                     game_done
);

   localparam int LOG_R  = $clog2(ROUNDS);
   localparam int RIDX_W = LOG_R + 1;
   localparam int SUM_W  = TIME_W + LOG_R;
   localparam int WAIT_W = $clog2(MIN_DELAY_MS + RAND_RANGE_MS);

   localparam logic [TIME_W-1:0] PENALTY    = TIME_W'(penalty_ms(TIMEOUT_MS, TIME_W));
   localparam logic [TIME_W-1:0] REACT_LAST = TIME_W'(TIMEOUT_MS - 1);
   localparam logic [TIME_W-1:0] BEST_NONE  = '1;
   localparam logic [RIDX_W-1:0] ROUND_LAST = RIDX_W'(ROUNDS);

   state_t              r_state;
   logic                r_led_go;
   logic                r_valid;
   logic                r_done;
   logic [TIME_W-1:0]   r_react;
   logic [TIME_W-1:0]   r_best;
   logic [TIME_W-1:0]   r_avg;
   logic [RIDX_W-1:0]   r_round;
   logic [SUM_W-1:0]    r_sum;
   logic [WAIT_W-1:0]   r_wait_target;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [TIME_W-1:0]   r_react_cnt;

   logic [15:0]         w_lfsr;
   logic [WAIT_W-1:0]   w_new_target;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (w_lfsr)
   );

   assign w_new_target = WAIT_W'(MIN_DELAY_MS + int'(w_lfsr & 16'(RAND_RANGE_MS - 1)));

   // NOTE: every output is a register updated here with <=, so outputs change
   // together with the state on the same edge and never glitch combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_led_go      <= 1'b0;
         r_valid       <= 1'b0;
         r_done        <= 1'b0;
         r_react       <= '0;
         r_best        <= BEST_NONE;
         r_avg         <= '0;
         r_round       <= '0;
         r_sum         <= '0;
         r_wait_target <= '0;
         r_wait_cnt    <= '0;
         r_react_cnt   <= '0;
      end else begin
         r_valid <= 1'b0;
         if (btn_clear && r_state != S_IDLE) begin
            r_state  <= S_IDLE;
            r_led_go <= 1'b0;
            r_done   <= 1'b0;
            r_react  <= '0;
            r_best   <= BEST_NONE;
            r_round  <= '0;
            r_sum    <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (btn_start) begin
                     r_state       <= S_WAIT;
                     r_wait_target <= w_new_target;
                     r_wait_cnt    <= '0;
                  end
               end
               S_WAIT: begin
                  if (btn_stop) begin
                     r_state <= S_EARLY;
                     r_react <= PENALTY;
                     r_valid <= 1'b1;
                     r_round <= r_round + RIDX_W'(1);
                     r_sum   <= r_sum + SUM_W'(PENALTY);
                  end else if (ms_tick) begin
                     if (r_wait_cnt == r_wait_target - WAIT_W'(1)) begin
                        r_state     <= S_GO;
                        r_led_go    <= 1'b1;
                        r_react_cnt <= '0;
                     end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                     end
                  end
               end
               S_GO: begin
                  // A stop arriving with a tick wins; that tick is not counted.
                  if (btn_stop) begin
                     r_state  <= S_HIT;
                     r_led_go <= 1'b0;
                     r_react  <= r_react_cnt;
                     r_valid  <= 1'b1;
                     r_round  <= r_round + RIDX_W'(1);
                     r_sum    <= r_sum + SUM_W'(r_react_cnt);
                     if (r_react_cnt < r_best) r_best <= r_react_cnt;
                  end else if (ms_tick) begin
                     if (r_react_cnt == REACT_LAST) begin
                        r_state  <= S_LATE;
                        r_led_go <= 1'b0;
                        r_react  <= PENALTY;
                        r_valid  <= 1'b1;
                        r_round  <= r_round + RIDX_W'(1);
                        r_sum    <= r_sum + SUM_W'(PENALTY);
                     end else begin
                        r_react_cnt <= r_react_cnt + TIME_W'(1);
                     end
                  end
               end
               S_HIT, S_LATE, S_EARLY: begin
                  if (btn_start) begin
                     if (r_round == ROUND_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_avg   <= TIME_W'(r_sum >> LOG_R);
                     end else begin
                        r_state       <= S_WAIT;
                        r_wait_target <= w_new_target;
                        r_wait_cnt    <= '0;
                     end
                  end
               end
               S_DONE: begin
                  if (btn_start) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b0;
                     r_react <= '0;
                     r_best  <= BEST_NONE;
                     r_round <= '0;
                     r_sum   <= '0;
                  end
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_led_go <= 1'b0;
                  r_done   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state_out    = r_state;
   assign led_go       = r_led_go;
   assign react_ms     = r_react;
   assign result_valid = r_valid;
   assign round_idx    = r_round;
   assign best_ms      = r_best;
   assign avg_ms       = r_avg;
   assign game_done    = r_done;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl: stimulus queues expected round
// results, a monitor pops and compares them on every result_valid pulse.
module tb_reaction_game_ctrl;

   localparam int CLK_P = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ms_tick = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_stop = 1'b0;
   logic       btn_clear = 1'b0;
   logic [2:0] state_out;
   logic       led_go;
   logic [9:0] react_ms;
   logic       result_valid;
   logic [2:0] round_idx;
   logic [9:0] best_ms;
   logic [9:0] avg_ms;
   logic       game_done;

   typedef struct {
      logic [2:0] st;
      logic [9:0] react;
      logic [2:0] rnd;
      logic [9:0] best;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] m_lfsr;
   int          first_tgt;

   reaction_game_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .ms_tick      (ms_tick),
      .btn_start    (btn_start),
      .btn_stop     (btn_stop),
      .btn_clear    (btn_clear),
      .state_out    (state_out),
      .led_go       (led_go),
      .react_ms     (react_ms),
      .result_valid (result_valid),
      .round_idx    (round_idx),
      .best_ms      (best_ms),
      .avg_ms       (avg_ms),
      .game_done    (game_done)
   );

   always #(CLK_P/2) clk = ~clk;

   // Reference random source: taps 16,14,13,11, shifting left, one step per clock.
   always @(posedge clk) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [2:0] st, input logic [9:0] react,
                       input logic [2:0] rnd, input logic [9:0] best);
      exp_t e;
      e.st = st; e.react = react; e.rnd = rnd; e.best = best;
      sb_q.push_back(e);
   endtask

   // Monitor: every result_valid pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: result_valid high with no result expected (t=%0t)", $time);
            end else begin
               e = sb_q.pop_front();
               check("res_state", 32'(state_out), 32'(e.st));
               check("res_react_ms", 32'(react_ms), 32'(e.react));
               check("res_round_idx", 32'(round_idx), 32'(e.rnd));
               check("res_best_ms", 32'(best_ms), 32'(e.best));
            end
         end
      end
   end

   initial begin
      #(CLK_P * 90000);
      $display("FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic press_start();
      btn_start = 1'b1; @(negedge clk); btn_start = 1'b0;
   endtask

   task automatic press_stop();
      btn_stop = 1'b1; @(negedge clk); btn_stop = 1'b0;
   endtask

   task automatic ticks(input int n);
      ms_tick = 1'b1;
      repeat (n) @(negedge clk);
      ms_tick = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_state"}, 32'(state_out), 0);
      check({tag, "_round_idx"}, 32'(round_idx), 0);
      check({tag, "_best_ms"}, 32'(best_ms), 1023);
      check({tag, "_react_ms"}, 32'(react_ms), 0);
      check({tag, "_led_go"}, 32'(led_go), 0);
      check({tag, "_game_done"}, 32'(game_done), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      check_cleared("reset");
      check("reset_result_valid", 32'(result_valid), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Start a round; the DUT loads its target from the LFSR value seen at this edge.
   task automatic start_round(output int tgt);
      tgt = 1000 + int'(m_lfsr & 16'h07FF);
      press_start();
      check("start_state_wait", 32'(state_out), 1);
   endtask

   task automatic reach_go(input int tgt);
      ticks(tgt - 1);
      check("wait_last_led_go", 32'(led_go), 0);
      check("wait_last_state", 32'(state_out), 1);
      ticks(1);
      check("go_led_go", 32'(led_go), 1);
      check("go_state", 32'(state_out), 2);
   endtask

   task automatic hit(input int n, input logic [2:0] rnd, input logic [9:0] best);
      ticks(n);
      push(3'd3, 10'(n), rnd, best);
      press_stop();
      check("hit_led_go_off", 32'(led_go), 0);
   endtask

   task automatic early(input int n, input logic [2:0] rnd, input logic [9:0] best);
      ticks(n);
      push(3'd5, 10'd1000, rnd, best);
      press_stop();
      check("early_state", 32'(state_out), 5);
   endtask

   initial begin
      int tgt;

      // Game A: late, then hits 237/180/300; average (1000+237+180+300)>>2 = 429.
      do_reset();
      start_round(tgt);
      first_tgt = tgt;
      reach_go(tgt);
      push(3'd4, 10'd1000, 3'd1, 10'd1023);
      ticks(999);
      check("go_before_timeout", 32'(state_out), 2);
      ticks(1);
      check("late_state", 32'(state_out), 4);
      check("late_led_go", 32'(led_go), 0);
      press_stop();
      check("stop_ignored_in_late", 32'(state_out), 4);

      start_round(tgt);
      press_start();
      check("start_ignored_in_wait", 32'(state_out), 1);
      reach_go(tgt + 0);
      press_start();
      check("start_ignored_in_go", 32'(state_out), 2);
      hit(237, 3'd2, 10'd237);

      start_round(tgt); reach_go(tgt); hit(180, 3'd3, 10'd180);
      start_round(tgt); reach_go(tgt); hit(300, 3'd4, 10'd180);
      press_start();
      check("done_state", 32'(state_out), 6);
      check("done_game_done", 32'(game_done), 1);
      check("done_avg_a", 32'(avg_ms), 429);
      check("done_best_a", 32'(best_ms), 180);
      press_start();
      check_cleared("done_exit_a");

      // Game B: early, same-cycle stop+tick at 999, then clear together with stop.
      start_round(tgt);
      early(5, 3'd1, 10'd1023);
      start_round(tgt); reach_go(tgt);
      ticks(999);
      push(3'd3, 10'd999, 3'd2, 10'd999);
      ms_tick = 1'b1; btn_stop = 1'b1;
      @(negedge clk);
      ms_tick = 1'b0; btn_stop = 1'b0;
      check("stop_tick_tie_state", 32'(state_out), 3);
      check("stop_tick_tie_react", 32'(react_ms), 999);
      start_round(tgt); reach_go(tgt);
      ticks(10);
      btn_clear = 1'b1; btn_stop = 1'b1;
      @(negedge clk);
      btn_clear = 1'b0; btn_stop = 1'b0;
      check_cleared("clear_in_go");
      check("clear_no_result", 32'(result_valid), 0);

      // Game C: 200/300/early/500 -> sum 2000, avg 500, best 200.
      start_round(tgt); reach_go(tgt); hit(200, 3'd1, 10'd200);
      start_round(tgt); reach_go(tgt); hit(300, 3'd2, 10'd200);
      start_round(tgt); early(5, 3'd3, 10'd200);
      start_round(tgt); reach_go(tgt); hit(500, 3'd4, 10'd200);
      press_start();
      check("done_game_done_c", 32'(game_done), 1);
      check("done_avg_c", 32'(avg_ms), 500);
      check("done_best_c", 32'(best_ms), 200);
      press_start();
      check_cleared("done_exit_c");

      // Game D: reset in the middle of GO; the random wait must replay the first one.
      start_round(tgt); reach_go(tgt); hit(100, 3'd1, 10'd100);
      start_round(tgt); reach_go(tgt);
      ticks(50);
      do_reset();
      btn_start = 1'b1; @(negedge clk); btn_start = 1'b0;
      check("restart_state_wait", 32'(state_out), 1);
      reach_go(first_tgt);
      hit(42, 3'd1, 10'd42);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
